// File: rtl/axi_pkg.sv
// Shared AXI read-side constants and the line reader state type.
// Latency: n/a (package).  Backpressure: n/a.
// Build option: AXI_RD_4K_SPLIT_EN (consumed by axi_line_reader).
package axi_pkg;
    localparam int         AXI_DATA_W  = 512;
    localparam int         AXI_ADDR_W  = 64;
    localparam int         LINE_BYTES  = 64;
    localparam logic [2:0] ARSIZE_64B  = 3'h6;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DRAIN
    } rd_state_e;
endpackage

// File: rtl/axi_rd_skid.sv
// Two-entry FIFO carrying {line data, last} between the R channel and the consumer.
// Latency: a push in cycle N is visible on out_valid_o in cycle N+1.
// Backpressure: in_ready_o drops only when both entries are occupied.
module axi_rd_skid #(
    parameter int W = 513
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    assign full        = (cnt_q == 2'd2);
    assign empty       = (cnt_q == 2'd0);
    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    assign push        = in_valid_i && !full;
    assign pop         = out_ready_i && !empty;
    assign out_data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data_i;
    end
endmodule

// File: rtl/axi_line_reader.sv
// AXI4 read master: one command becomes a chain of AR bursts, lines streamed out in order.
// Latency: AR on the cycle after accept; an R beat reaches out_valid one cycle later.
// Backpressure: rready_m drops when the 2-entry output buffer is full. Option: AXI_RD_4K_SPLIT_EN.
module axi_line_reader
    import axi_pkg::*;
#(
    parameter logic [15:0] ARID_VAL  = 16'h0,
    parameter int          MAX_BURST = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [63:0]  cmd_addr,
    input  logic [31:0]  cmd_lines,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_data,
    output logic         out_last,
    output logic         done,
    output logic         err,
    output logic [15:0]  arid_m,
    output logic [63:0]  araddr_m,
    output logic [7:0]   arlen_m,
    output logic [2:0]   arsize_m,
    output logic         arvalid_m,
    input  logic         arready_m,
    input  logic [15:0]  rid_m,
    input  logic [511:0] rdata_m,
    input  logic [1:0]   rresp_m,
    input  logic         rlast_m,
    input  logic         rvalid_m,
    output logic         rready_m
);
    rd_state_e    state_q, state_d;
    logic [63:0]  cur_addr_q, cur_addr_d;
    logic [32:0]  rem_q, rem_d;
    logic [8:0]   beats_q, beats_d;
    logic [8:0]   cnt_q, cnt_d;
    logic         err_q, err_d;
    logic         done_q, done_d;

    logic [8:0]   burst_beats;
    logic [32:0]  rem_after;
    logic [63:0]  addr_after;
    logic         beat_hs;
    logic         beat_last;
    logic         beat_bad;
    logic         skid_in_rdy;
    logic         skid_out_vld;
    logic [512:0] skid_out_dat;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^cmd_addr[5:0];

`ifdef AXI_RD_4K_SPLIT_EN
    logic [6:0] bnd_lim;
    assign bnd_lim = 7'd64 - {1'b0, cur_addr_q[11:6]};
`endif

    always_comb begin
        burst_beats = (rem_q < 33'(MAX_BURST)) ? rem_q[8:0] : 9'(MAX_BURST);
`ifdef AXI_RD_4K_SPLIT_EN
        if (burst_beats > {2'b00, bnd_lim}) burst_beats = {2'b00, bnd_lim};
`endif
    end

    assign rem_after  = rem_q - {24'd0, beats_q};
    assign addr_after = cur_addr_q + {49'd0, beats_q, 6'd0};

    // The local beat counter, not rlast_m, delimits each burst.
    assign beat_hs   = rvalid_m && (state_q == ST_DATA) && skid_in_rdy;
    assign beat_last = (cnt_q == 9'd1);
    assign beat_bad  = (rlast_m != beat_last) || (rresp_m != RESP_OKAY) || (rid_m != ARID_VAL);

    assign araddr_m  = cur_addr_q;
    assign arlen_m   = 8'(burst_beats - 9'd1);
    assign arsize_m  = ARSIZE_64B;
    assign arid_m    = ARID_VAL;

    // Held off while done is pulsing so a new command never overlaps the old one.
    assign cmd_ready = (state_q == ST_IDLE) && !done_q && !rst;
    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = skid_out_vld;
    assign out_data  = skid_out_dat[512:1];
    assign out_last  = skid_out_dat[0] && skid_out_vld;

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        rem_d      = rem_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        done_d     = 1'b0;
        arvalid_m  = 1'b0;
        rready_m   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cur_addr_d = {cmd_addr[63:6], 6'd0};
                    rem_d      = {1'b0, cmd_lines};
                    err_d      = 1'b0;
                    if (cmd_lines == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                arvalid_m = 1'b1;
                if (arready_m) begin
                    beats_d = burst_beats;
                    cnt_d   = burst_beats;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                rready_m = skid_in_rdy;
                if (beat_hs) begin
                    cnt_d = cnt_q - 9'd1;
                    if (beat_bad) err_d = 1'b1;
                    if (beat_last) begin
                        rem_d      = rem_after;
                        cur_addr_d = addr_after;
                        state_d    = (rem_after == 33'd0) ? ST_DRAIN : ST_ADDR;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_valid && out_ready && out_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= 64'd0;
            rem_q      <= 33'd0;
            beats_q    <= 9'd0;
            cnt_q      <= 9'd0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            rem_q      <= rem_d;
            beats_q    <= beats_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    axi_rd_skid #(
        .W (513)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rvalid_m && (state_q == ST_DATA)),
        .in_ready_o  (skid_in_rdy),
        .in_data_i   ({rdata_m, beat_last && (rem_after == 33'd0)}),
        .out_valid_o (skid_out_vld),
        .out_ready_i (out_ready),
        .out_data_o  (skid_out_dat)
    );
endmodule

// File: tb/tb_axi_line_reader.sv
// Bench for axi_line_reader: table of commands, random backpressure run, reset/zero-length sequences.
// A behavioural memory responder plus a queue model of expected ARs and output lines.
module tb_axi_line_reader;
    logic         clk = 1'b0;
    logic         rst, cmd_valid, cmd_ready;
    logic [63:0]  cmd_addr;
    logic [31:0]  cmd_lines;
    logic         out_valid, out_ready, out_last, done, err;
    logic [511:0] out_data;
    logic [15:0]  arid_m, rid_m;
    logic [63:0]  araddr_m;
    logic [7:0]   arlen_m;
    logic [2:0]   arsize_m;
    logic         arvalid_m, arready_m;
    logic [511:0] rdata_m;
    logic [1:0]   rresp_m;
    logic         rlast_m, rvalid_m, rready_m;

    always #5 clk = ~clk;

    axi_line_reader #(.ARID_VAL(16'h0), .MAX_BURST(256)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_lines(cmd_lines), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .err(err), .arid_m(arid_m), .araddr_m(araddr_m),
        .arlen_m(arlen_m), .arsize_m(arsize_m), .arvalid_m(arvalid_m),
        .arready_m(arready_m), .rid_m(rid_m), .rdata_m(rdata_m),
        .rresp_m(rresp_m), .rlast_m(rlast_m), .rvalid_m(rvalid_m), .rready_m(rready_m)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
    typedef struct { logic [511:0] d; logic last; } line_t;
    typedef struct {
        logic [63:0] addr; int lines; int inj_kind; int inj_k;
        int nar; logic [63:0] first_addr; int first_len; int last_len; logic exp_err;
    } vec_t;

    int n_pass = 0, n_total = 0;
    ar_t   exp_ar_q[$];
    line_t exp_ln_q[$];
    ar_t   rsp_q[$];
    int rsp_beat = 0, r_total = 0, inj_abs = -1, inj_kind = 0, inj_k = 0;
    int p_ar = 100, p_rv = 100, p_or = 100;
    int occ = 0, tick_no = 0;
    bit r_pend = 0, cmd_acc = 0;
    int acc_tick, done_tick, done_cnt, ar_cnt, out_cnt, first_arlen, last_arlen, done_lat;
    logic [63:0] first_araddr;
    logic err_at_done;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    endtask

    function automatic logic [511:0] pat(input logic [63:0] a);
        return {4{a, ~a}};
    endfunction

    // Reference: split the command into bursts and list every line it must produce.
    task automatic build_model(input logic [63:0] addr, input int lines);
        logic [63:0] a;
        longint r, b, lim;
        ar_t e;
        line_t l;
        a = {addr[63:6], 6'd0};
        for (int i = 0; i < lines; i++) begin
            l.d = pat(a + 64'(i) * 64'd64);
            l.last = (i == lines - 1);
            exp_ln_q.push_back(l);
        end
        r = lines;
        while (r > 0) begin
            b = (r > 256) ? 256 : r;
`ifdef AXI_RD_4K_SPLIT_EN
            lim = 64 - longint'(a[11:6]);
            if (b > lim) b = lim;
`else
            lim = b;
`endif
            e.addr = a;
            e.len = 8'(b - 1);
            exp_ar_q.push_back(e);
            a = a + 64'(b) * 64'd64;
            r -= b;
        end
    endtask

    task automatic drive_resp();
        logic [63:0] a;
        arready_m = ($urandom_range(0, 99) < p_ar);
        out_ready = ($urandom_range(0, 99) < p_or);
        if (!r_pend && rsp_q.size() > 0 && $urandom_range(0, 99) < p_rv) begin
            a = rsp_q[0].addr + 64'(rsp_beat) * 64'd64;
            rdata_m = pat(a);
            rlast_m = (rsp_beat == int'(rsp_q[0].len));
            rresp_m = 2'b00;
            rid_m = 16'h0;
            if (r_total == inj_abs) begin
                case (inj_kind)
                    1: rresp_m = 2'b10;
                    2: rid_m = 16'h5;
                    3: rlast_m = ~rlast_m;
                    default: ;
                endcase
            end
            r_pend = 1;
        end
        rvalid_m = r_pend;
    endtask

    task automatic sample();
        bit r_hs, o_hs;
        ar_t e;
        line_t l;
        if (rst) begin
            exp_ar_q.delete(); exp_ln_q.delete(); rsp_q.delete();
            r_pend = 0; rsp_beat = 0; occ = 0;
            return;
        end
        if (cmd_valid && cmd_ready) begin
            build_model(cmd_addr, int'(cmd_lines));
            cmd_acc = 1; acc_tick = tick_no; ar_cnt = 0; out_cnt = 0; done_cnt = 0;
            err_at_done = 1'bx;
            inj_abs = (inj_kind != 0) ? r_total + inj_k : -1;
        end
        if (arvalid_m && arready_m) begin
            chk("ar_was_expected", exp_ar_q.size() != 0, 1'b1);
            if (exp_ar_q.size() != 0) begin
                e = exp_ar_q.pop_front();
                chk("araddr", araddr_m, e.addr);
                chk("arlen", arlen_m, e.len);
            end
            chk("arsize", arsize_m, 3'h6);
            chk("arid", arid_m, 16'h0);
            if (ar_cnt == 0) begin first_araddr = araddr_m; first_arlen = int'(arlen_m); end
            last_arlen = int'(arlen_m);
            ar_cnt++;
            e.addr = araddr_m; e.len = arlen_m;
            rsp_q.push_back(e);
        end
        r_hs = rvalid_m && rready_m;
        if (r_hs) begin
            r_pend = 0; r_total++; rsp_beat++;
            if (rsp_beat > int'(rsp_q[0].len)) begin void'(rsp_q.pop_front()); rsp_beat = 0; end
        end
        chk("rready_while_buffer_full", rready_m && (occ == 2), 1'b0);
        chk("out_valid_vs_occupancy", out_valid, occ != 0);
        o_hs = out_valid && out_ready;
        if (o_hs) begin
            chk("line_was_expected", exp_ln_q.size() != 0, 1'b1);
            if (exp_ln_q.size() != 0) begin
                l = exp_ln_q.pop_front();
                chk("out_data", out_data, l.d);
                chk("out_last", out_last, l.last);
            end
            out_cnt++;
        end
        if (done) begin done_cnt++; done_tick = tick_no; err_at_done = err; end
        occ = occ + int'(r_hs) - int'(o_hs);
    endtask

    task automatic tick();
        drive_resp();
        #1;
        sample();
        tick_no++;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_arvalid"}, arvalid_m, 1'b0);
        chk({tag, "_rready"}, rready_m, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_out_last"}, out_last, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    endtask

    task automatic run_cmd(input logic [63:0] addr, input int lines);
        cmd_addr = addr; cmd_lines = 32'(lines); cmd_valid = 1; cmd_acc = 0;
        for (int i = 0; i < 50 && !cmd_acc; i++) tick();
        cmd_valid = 0;
        chk("cmd_accepted", cmd_acc, 1'b1);
        chk("err_cleared_on_accept", err, 1'b0);
        for (int i = 0; i < lines * 12 + 200 && done_cnt == 0; i++) tick();
        for (int i = 0; i < 3; i++) tick();
        chk("done_single_pulse", done_cnt, 1);
        chk("all_ars_issued", exp_ar_q.size(), 0);
        chk("all_lines_out", exp_ln_q.size(), 0);
        chk("out_count", out_cnt, lines);
        done_lat = done_tick - acc_tick;
    endtask

    initial begin
        rst = 1; cmd_valid = 0; cmd_addr = '0; cmd_lines = '0;
        arready_m = 0; rvalid_m = 0; rdata_m = '0; rresp_m = 0; rlast_m = 0; rid_m = 0; out_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        check_reset_outputs("reset");
        rst = 0;
        tick();
        chk("cmd_ready_after_reset", cmd_ready, 1'b1);

        vecs[0]  = '{64'h40, 1, 0, 0, 1, 64'h40, 0, 0, 1'b0};
        vecs[2]  = '{64'h7F, 3, 0, 0, 1, 64'h40, 2, 2, 1'b0};
        vecs[5]  = '{64'h1234, 0, 0, 0, 0, 64'h0, 0, 0, 1'b0};
        vecs[7]  = '{64'h2000, 4, 1, 1, 1, 64'h2000, 3, 3, 1'b1};
        vecs[8]  = '{64'h3000, 4, 0, 0, 1, 64'h3000, 3, 3, 1'b0};
        vecs[9]  = '{64'h4000, 2, 2, 0, 1, 64'h4000, 1, 1, 1'b1};
        vecs[10] = '{64'h5000, 4, 3, 3, 1, 64'h5000, 3, 3, 1'b1};
        vecs[11] = '{64'h5040, 5, 3, 1, 1, 64'h5040, 4, 4, 1'b1};
`ifdef AXI_RD_4K_SPLIT_EN
        vecs[1]  = '{64'h0, 600, 0, 0, 10, 64'h0, 63, 23, 1'b0};
        vecs[3]  = '{64'hFC0, 3, 0, 0, 2, 64'hFC0, 0, 1, 1'b0};
        vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFC0, 2, 0, 0, 2, 64'hFFFF_FFFF_FFFF_FFC0, 0, 0, 1'b0};
        vecs[6]  = '{64'h1000, 257, 0, 0, 5, 64'h1000, 63, 0, 1'b0};
`else
        vecs[1]  = '{64'h0, 600, 0, 0, 3, 64'h0, 255, 87, 1'b0};
        vecs[3]  = '{64'hFC0, 3, 0, 0, 1, 64'hFC0, 2, 2, 1'b0};
        vecs[4]  = '{64'hFFFF_FFFF_FFFF_FFC0, 2, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFC0, 1, 1, 1'b0};
        vecs[6]  = '{64'h1000, 257, 0, 0, 2, 64'h1000, 255, 0, 1'b0};
`endif
        p_ar = 100; p_rv = 100; p_or = 100;
        foreach (vecs[i]) begin
            inj_kind = vecs[i].inj_kind; inj_k = vecs[i].inj_k;
            run_cmd(vecs[i].addr, vecs[i].lines);
            inj_kind = 0;
            chk($sformatf("v%0d_ar_count", i), ar_cnt, vecs[i].nar);
            if (vecs[i].nar > 0) begin
                chk($sformatf("v%0d_first_araddr", i), first_araddr, vecs[i].first_addr);
                chk($sformatf("v%0d_first_arlen", i), first_arlen, vecs[i].first_len);
                chk($sformatf("v%0d_last_arlen", i), last_arlen, vecs[i].last_len);
            end
            chk($sformatf("v%0d_err_at_done", i), err_at_done, vecs[i].exp_err);
            chk($sformatf("v%0d_throughput", i), done_lat <= vecs[i].lines + 2 * vecs[i].nar + 4, 1'b1);
            if (vecs[i].lines == 0) chk($sformatf("v%0d_zero_len_done_latency", i), done_lat, 1);
        end

        // Random addresses and lengths under heavy consumer and responder backpressure.
        p_ar = 50; p_rv = 60; p_or = 30;
        for (int n = 0; n < 12; n++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if (n % 4 == 0) a[63:12] = '1;
            run_cmd(a, int'($urandom_range(0, 40)));
            chk("random_err_at_done", err_at_done, 1'b0);
        end

        // Reset in the middle of a burst, then confirm a clean restart.
        p_ar = 100; p_rv = 100; p_or = 100;
        cmd_addr = 64'h8000; cmd_lines = 32'd50; cmd_valid = 1; cmd_acc = 0;
        for (int i = 0; i < 50 && !cmd_acc; i++) tick();
        cmd_valid = 0;
        for (int i = 0; i < 40 && out_cnt < 3; i++) tick();
        chk("mid_data_reached", rready_m, 1'b1);
        rst = 1;
        tick();
        check_reset_outputs("mid_reset");
        rst = 0;
        tick();
        chk("cmd_ready_after_mid_reset", cmd_ready, 1'b1);
        run_cmd(64'h40, 1);
        chk("post_reset_ar_count", ar_cnt, 1);
        chk("post_reset_err", err_at_done, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_line_reader.md
# axi_line_reader

AXI4 read master that fetches a contiguous run of 512-bit (64-byte) lines from memory and streams them out in order. It is the initiator counterpart of the memory-side AXI responder and sits between the PageRank compute pipeline and the memory port. One command yields a sequence of AR bursts, one outstanding at a time. Data passes through a 2-entry output buffer.

## Interface
Parameters:
- ARID_VAL, 16'h0: constant value driven on arid_m.
- MAX_BURST, 256: maximum beats per burst, legal range 1..256.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_addr  in  64  start byte address; bits [5:0] are ignored (line-aligned).
- cmd_lines  in  32  number of lines to read.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the current line.
- out_data  out  512  line data.
- out_last  out  1  final line of the command.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  sticky error flag; cleared on the next command accept.
- arid_m out 16, araddr_m out 64, arlen_m out 8, arsize_m out 3, arvalid_m out 1, arready_m in 1: AR channel.
- rid_m in 16, rdata_m in 512, rresp_m in 2, rlast_m in 1, rvalid_m in 1, rready_m out 1: R channel.

## Operation
- States:
  - IDLE: cmd_ready=1. On cmd_valid, latch cur_addr={cmd_addr[63:6],6'b0} and rem=cmd_lines, and clear err.
    - rem==0: pulse done on the next cycle and stay in IDLE.
    - Otherwise go to ADDR.
  - ADDR: arvalid_m=1, araddr_m=cur_addr, arlen_m=beats-1, arsize_m=3'h6, arid_m=ARID_VAL. These values are held stable until arready_m. On the handshake, go to DATA.
  - DATA: rready_m=1 while the output buffer has a free slot. Each accepted beat is pushed into the buffer and decrements the internal beat counter.
    - When the counter reaches 0: rem-=beats and cur_addr+=beats*64.
    - rem==0 -> DRAIN; otherwise -> ADDR.
  - DRAIN: wait for the out_last line to be accepted, then pulse done and go to IDLE.
- Burst size: beats = min(rem, MAX_BURST, boundary limit). The boundary limit is set under Configuration. Arithmetic is 33-bit for rem and 64-bit for the address; the address wraps modulo 2^64 without error.
- Burst termination: the internal beat counter ends the burst, not rlast_m. err is set if:
  - rlast_m disagrees with the counter on any beat;
  - rresp_m!=0 on any beat;
  - rid_m!=ARID_VAL on any beat.
- Data is always forwarded, even when err is set.
- out_last is high only on the command's final line.

## Timing
- Reset values: arvalid_m=0, rready_m=0, out_valid=0, out_last=0, done=0, err=0, cmd_ready=0. State is IDLE, so cmd_ready=1 from the first cycle after rst is released.
- First AR request: arvalid_m is high on the cycle after the command is accepted.
- Output latency: an R beat accepted in cycle N appears on out_valid in cycle N+1 when the buffer was empty.
- Throughput: 1 line/cycle while out_ready is held high.
- Buffer full: rready_m=0 and the R channel stalls with no data loss.
- Back-to-back commands: no new command is accepted until done has pulsed. cmd_ready can be high in the cycle after done.
- Reset mid-command discards all state, including buffered lines. The system must reset the memory responder in the same cycle.

## Configuration
- AXI_RD_4K_SPLIT_EN defined: bursts never cross a 4 KB boundary. Boundary limit = 64 - cur_addr[11:6], so a burst is at most 64 beats.
- Undefined: there is no boundary limit, and bursts are capped only by MAX_BURST and rem.

## Structure
- Shared package axi_pkg holds:
  - AXI_DATA_W=512 and AXI_ADDR_W=64;
  - LINE_BYTES=64 and ARSIZE_64B=3'h6;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the state enum type.
- Sub-module axi_rd_skid: a 2-entry FIFO carrying {data, last}, with valid/ready on both sides and its own full/empty logic.

## Test plan
- Single line: cmd_addr=0x40, cmd_lines=1 -> one AR with araddr=0x40 and arlen=0, then one out beat with out_last=1, then done; err=0.
- Long run without AXI_RD_4K_SPLIT_EN: cmd_addr=0, cmd_lines=600 with MAX_BURST=256 -> ARs with arlen 255, 255, 87 at addresses 0x0, 0x4000, 0x8000.
- Long run with AXI_RD_4K_SPLIT_EN: cmd_addr=0xFC0, cmd_lines=3 -> AR(0xFC0, arlen=0), then AR(0x1000, arlen=1).
- Backpressure: out_ready toggles randomly with a 30% duty cycle -> all lines appear in order, none are duplicated, and rready_m is never high while the buffer is full.
- Errors: the responder returns rresp=2'b10 on beat 2 of 4 -> all 4 lines are output and err=1 after done. err clears when the next command is accepted.
- Zero length and reset:
  - cmd_lines=0 -> no AR and done one cycle later.
  - rst asserted mid-DATA -> all outputs return to their reset values on the next cycle.
